// File: rtl/booth_pp_gen.sv
// -----------------------------------------------------------------------------
// booth_pp_gen
//
// Radix-4 Booth partial-product generator feeding the per-column Wallace-tree
// slices of the 32x32 multiplier.  One operand pair is accepted per operation.
// The 17 Booth partial products are built sequentially and scattered into 64
// column vectors.  Column c holds bit c of every partial product, which is the
// slice of the array one Wallace column needs.  The block then raises
// swt_begin and holds it until the slices report swt_end.
//
// Optional build macro:
//   PP_GEN_DUAL_EN  - two partial products per GEN cycle: 9 GEN cycles instead
//                     of 17.  Column contents are identical in both builds.
//
// Ports:
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   mul_start  in   operation request, sampled only while idle
//   mul_signed in   1 = signed operands, latched with mul_start
//   x, y       in   multiplicand / multiplier, latched with mul_start
//   busy       out  high in every state except IDLE
//   pp_valid   out  pp_cols stable and valid (ISSUE)
//   pp_cols    out  column c = bits [NPP*c+NPP-1 : NPP*c], bit i = pp_i[c]
//   swt_begin  out  start/hold to the Wallace slices (ISSUE)
//   swt_end    in   AND of all slice completion flags
//   done       out  one-cycle completion pulse
//
// Timing: a start accepted at edge T gives pp_valid/swt_begin high after edge
// T+18 (T+10 in the dual build).  Each computed row is registered once before
// it is scattered across the 64 columns, so the column write trails the Booth
// computation by one cycle and the wide fan-out starts from a flop.
// -----------------------------------------------------------------------------
module booth_pp_gen #(
    parameter int XLEN = 32,
    parameter int NPP  = (XLEN + 2) / 2,
    parameter int PW   = 2 * XLEN
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mul_start,
    input  logic              mul_signed,
    input  logic [XLEN-1:0]   x,
    input  logic [XLEN-1:0]   y,
    output logic              busy,
    output logic              pp_valid,
    output logic [PW*NPP-1:0] pp_cols,
    output logic              swt_begin,
    input  logic              swt_end,
    output logic              done
);

    // Index register must count past the last row (up to NPP+1 in the dual build).
    localparam int IW = $clog2(NPP + 2);

`ifdef PP_GEN_DUAL_EN
    localparam logic [IW-1:0] STEP = IW'(2);
`else
    localparam logic [IW-1:0] STEP = IW'(1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GEN,
        ST_ISSUE,
        ST_DONE
    } state_t;

    state_t state_q, state_d;

    // Operands stored already extended: X to XLEN+1 bits, Y to XLEN+2 bits.
    logic [XLEN:0]   x_q;
    logic [XLEN+1:0] y_q;
    logic [IW-1:0]   idx_q;

    // One-deep row stage between the Booth selector and the column scatter.
    logic            row_vld_q;
    logic [IW-1:0]   row_idx_q;
    logic [PW-1:0]   row_lo_q;
`ifdef PP_GEN_DUAL_EN
    logic            row_hi_vld_q;
    logic [PW-1:0]   row_hi_q;
    logic [PW-1:0]   pp_hi;
`endif

    logic [NPP-1:0]  col_q [PW];

    logic            gen_more;
    logic            last_write;
    logic [PW-1:0]   pp_lo;

    // -------------------------------------------------------------------------
    // Booth partial product i: recode {Y[2i+1],Y[2i],Y[2i-1]} to a digit in
    // {-2..+2}, apply it to the sign-extended multiplicand with a full two's
    // complement negate, then weight by 4^i.  Everything wraps at PW bits.
    // -------------------------------------------------------------------------
    function automatic logic [PW-1:0] booth_pp(
        input logic [XLEN:0]   xe,
        input logic [XLEN+1:0] ye,
        input logic [IW-1:0]   i
    );
        logic [XLEN+5:0] yz;
        logic [2:0]      grp;
        logic [PW-1:0]   xs;
        logic [PW-1:0]   mag;
        logic            neg;
        // Extra sign padding on top keeps the group select in range for the
        // index one past the last row, which the dual build may evaluate.
        yz  = {{3{ye[XLEN+1]}}, ye, 1'b0};
        grp = yz[{i, 1'b0} +: 3];
        xs  = {{(PW-XLEN-1){xe[XLEN]}}, xe};
        case (grp)
            3'b001, 3'b010, 3'b101, 3'b110: mag = xs;
            3'b011, 3'b100:                 mag = xs << 1;
            default:                        mag = '0;
        endcase
        neg = grp[2] & ~(grp[1] & grp[0]);
        return (neg ? (~mag + PW'(1)) : mag) << {i, 1'b0};
    endfunction

    assign gen_more   = (state_q == ST_GEN) && (idx_q < IW'(NPP));
    // The row stage holds the last row exactly when its low index is NPP-1
    // (in the dual build that row is written alone).
    assign last_write = row_vld_q && (row_idx_q == IW'(NPP - 1));
    assign pp_lo      = booth_pp(x_q, y_q, idx_q);
`ifdef PP_GEN_DUAL_EN
    assign pp_hi      = booth_pp(x_q, y_q, idx_q + IW'(1));
`endif

    // -------------------------------------------------------------------------
    // State register and control path
    // -------------------------------------------------------------------------
    // NOTE: every clocked process uses non-blocking assignments so all flops
    // update together from the values that were present before the edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (mul_start)  state_d = ST_GEN;
            ST_GEN:   if (last_write) state_d = ST_ISSUE;
            ST_ISSUE: if (swt_end)    state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Outputs decode straight from the state flop, so an asynchronous reset
    // clears them immediately.
    assign busy      = (state_q != ST_IDLE);
    assign pp_valid  = (state_q == ST_ISSUE);
    assign swt_begin = (state_q == ST_ISSUE);
    assign done      = (state_q == ST_DONE);

    // -------------------------------------------------------------------------
    // Operand latch and row index
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q   <= '0;
            y_q   <= '0;
            idx_q <= '0;
        end else if (state_q == ST_IDLE) begin
            if (mul_start) begin
                x_q   <= {mul_signed & x[XLEN-1], x};
                y_q   <= {{2{mul_signed & y[XLEN-1]}}, y};
                idx_q <= '0;
            end
        end else if (gen_more) begin
            idx_q <= idx_q + STEP;
        end
    end

    // -------------------------------------------------------------------------
    // Row stage
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_vld_q    <= 1'b0;
            row_idx_q    <= '0;
            row_lo_q     <= '0;
`ifdef PP_GEN_DUAL_EN
            row_hi_vld_q <= 1'b0;
            row_hi_q     <= '0;
`endif
        end else begin
            row_vld_q <= gen_more;
            if (gen_more) begin
                row_idx_q    <= idx_q;
                row_lo_q     <= pp_lo;
`ifdef PP_GEN_DUAL_EN
                row_hi_vld_q <= (idx_q + IW'(1)) < IW'(NPP);
                row_hi_q     <= pp_hi;
`endif
            end
        end
    end

    // -------------------------------------------------------------------------
    // Column store: bit c of the registered row lands in column c, bit row_idx.
    // Contents persist after DONE until overwritten by the next operation.
    // -------------------------------------------------------------------------
    // NOTE: this array is deliberately reset, because reset must drive pp_cols
    // to zero; storage with no such requirement would normally be left unreset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < PW; c++) begin
                col_q[c] <= '0;
            end
        end else if (row_vld_q) begin
            for (int c = 0; c < PW; c++) begin
                col_q[c][row_idx_q] <= row_lo_q[c];
`ifdef PP_GEN_DUAL_EN
                if (row_hi_vld_q) begin
                    col_q[c][row_idx_q + IW'(1)] <= row_hi_q[c];
                end
`endif
            end
        end
    end

    for (genvar c = 0; c < PW; c++) begin : g_cols
        assign pp_cols[c*NPP +: NPP] = col_q[c];
    end

endmodule

// File: tb/tb_booth_pp_gen.sv
// -----------------------------------------------------------------------------
// tb_booth_pp_gen
//
// Self-checking bench for booth_pp_gen.  The reference model works from the
// arithmetic definition: each Booth digit is -2*Y[2i+1] + Y[2i] + Y[2i-1].
// Each partial product is digit * X * 4^i mod 2^64.  The column sum is compared
// with the plain 64-bit product.
// -----------------------------------------------------------------------------
module tb_booth_pp_gen;

    localparam int NPP = 17;
    localparam int PW  = 64;
`ifdef PP_GEN_DUAL_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 18;
`endif

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic              mul_start = 1'b0;
    logic              mul_signed = 1'b0;
    logic [31:0]       x = '0;
    logic [31:0]       y = '0;
    logic              swt_end = 1'b0;
    logic              busy;
    logic              pp_valid;
    logic [PW*NPP-1:0] pp_cols;
    logic              swt_begin;
    logic              done;

    int total = 0;
    int bad   = 0;

    booth_pp_gen dut (
        .clk       (clk),
        .resetn    (resetn),
        .mul_start (mul_start),
        .mul_signed(mul_signed),
        .x         (x),
        .y         (y),
        .busy      (busy),
        .pp_valid  (pp_valid),
        .pp_cols   (pp_cols),
        .swt_begin (swt_begin),
        .swt_end   (swt_end),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic longint ext(input logic [31:0] v, input bit s);
        return s ? longint'($signed(v)) : longint'({32'b0, v});
    endfunction

    function automatic longint ybit(input longint yv, input int k);
        if (k < 0) return 0;
        return (yv >>> k) & 64'sd1;
    endfunction

    function automatic logic [63:0] model_pp(input logic [31:0] a, input logic [31:0] b,
                                             input bit s, input int i);
        longint xv, yv, d;
        xv = ext(a, s);
        yv = ext(b, s);
        d  = -2 * ybit(yv, 2*i+1) + ybit(yv, 2*i) + ybit(yv, 2*i-1);
        return 64'(d * xv) << (2 * i);
    endfunction

    function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b,
                                               input bit s);
        return 64'(ext(a, s) * ext(b, s));
    endfunction

    function automatic logic [63:0] get_pp(input logic [PW*NPP-1:0] cols, input int i);
        logic [63:0] p;
        for (int c = 0; c < PW; c++) p[c] = cols[NPP*c + i];
        return p;
    endfunction

    // ---------------- drivers ----------------
    // Present a request, let edge T accept it, then count edges until swt_begin.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit s,
                            output int lat);
        @(posedge clk); #1;
        x = a; y = b; mul_signed = s; mul_start = 1'b1;
        @(posedge clk); #1;
        mul_start = 1'b0;
        lat = 0;
        while (!swt_begin && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Columns and their sum against the model.
    task automatic compare_cols(input string name, input logic [31:0] a,
                                input logic [31:0] b, input bit s);
        logic [63:0] got, exp, sum;
        sum = '0;
        for (int i = 0; i < NPP; i++) begin
            got = get_pp(pp_cols, i);
            exp = model_pp(a, b, s, i);
            sum += got;
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL %s pp_%0d: got %h expected %h", name, i, got, exp);
            end
        end
        total++;
        if (sum !== model_prod(a, b, s)) begin
            bad++;
            $display("FAIL %s column_sum: got %h expected %h", name, sum, model_prod(a, b, s));
        end
    endtask

    // Pulse swt_end in ISSUE; done must follow for exactly one cycle.
    task automatic finish_op(input string name);
        swt_end = 1'b1;
        @(posedge clk); #1;
        swt_end = 1'b0;
        total++;
        if (!(done === 1'b1 && swt_begin === 1'b0 && pp_valid === 1'b0 && busy === 1'b1)) begin
            bad++;
            $display("FAIL %s done_cycle: done=%b swt_begin=%b pp_valid=%b busy=%b required 1 0 0 1",
                     name, done, swt_begin, pp_valid, busy);
        end
        @(posedge clk); #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after_done: done=%b busy=%b required 0 0", name, done, busy);
        end
    endtask

    task automatic check_latency(input string name, input int lat);
        total++;
        if (lat !== LAT) begin
            bad++;
            $display("FAIL %s latency: swt_begin after edge T+%0d required T+%0d", name, lat, LAT);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total += 5;
        if (busy      !== 1'b0) begin bad++; $display("FAIL reset busy: %b required 0", busy); end
        if (pp_valid  !== 1'b0) begin bad++; $display("FAIL reset pp_valid: %b required 0", pp_valid); end
        if (swt_begin !== 1'b0) begin bad++; $display("FAIL reset swt_begin: %b required 0", swt_begin); end
        if (done      !== 1'b0) begin bad++; $display("FAIL reset done: %b required 0", done); end
        if (pp_cols   !== '0)   begin bad++; $display("FAIL reset pp_cols: nonzero, required 0"); end
        resetn = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] ta [3] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] tb [3] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        bit          ts [3] = '{1'b0, 1'b1, 1'b0};
        logic [63:0] tp [3] = '{64'd15, 64'd1, 64'hFFFF_FFFE_0000_0001};
        logic [63:0] sum;
        int lat;
        for (int k = 0; k < 3; k++) begin
            start_op(ta[k], tb[k], ts[k], lat);
            check_latency("directed", lat);
            compare_cols("directed", ta[k], tb[k], ts[k]);
            sum = '0;
            for (int i = 0; i < NPP; i++) sum += get_pp(pp_cols, i);
            total++;
            if (sum !== tp[k]) begin
                bad++;
                $display("FAIL directed product_%0d: got %h expected %h", k, sum, tp[k]);
            end
            if (k == 2) begin
                total += 2;
                if (get_pp(pp_cols, 0) !== 64'hFFFF_FFFF_0000_0001) begin
                    bad++;
                    $display("FAIL umax pp_0: got %h expected ffffffff00000001", get_pp(pp_cols, 0));
                end
                if (get_pp(pp_cols, 16) !== 64'hFFFF_FFFF_0000_0000) begin
                    bad++;
                    $display("FAIL umax pp_16: got %h expected ffffffff00000000", get_pp(pp_cols, 16));
                end
            end
            finish_op("directed");
        end
    endtask

    task automatic test_handshake();
        int lat, errs;
        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, lat);
        check_latency("handshake", lat);
        errs = 0;
        for (int c = 0; c < 20; c++) begin
            if (!(swt_begin === 1'b1 && pp_valid === 1'b1 && busy === 1'b1 && done === 1'b0))
                errs++;
            @(posedge clk); #1;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL handshake hold: %0d bad cycles of 20, required 0", errs);
        end
        compare_cols("handshake", 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        finish_op("handshake");
    endtask

    task automatic test_ignore_start();
        int lat, dones;
        @(posedge clk); #1;
        x = 32'd3; y = 32'd5; mul_signed = 1'b0; mul_start = 1'b1;
        @(posedge clk); #1;
        mul_start = 1'b0;
        lat = 0;
        while (!swt_begin && lat < 200) begin
            // Intruding request and stray swt_end during GEN must be ignored.
            mul_start = (lat == 3);
            if (lat == 3) x = 32'd7;
            swt_end = (lat == 5);
            @(posedge clk); #1;
            lat++;
        end
        mul_start = 1'b0;
        swt_end = 1'b0;
        check_latency("ignore_start", lat);
        compare_cols("ignore_start", 32'd3, 32'd5, 1'b0);
        finish_op("ignore_start");
        dones = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        total++;
        if (dones != 0) begin
            bad++;
            $display("FAIL ignore_start extra_activity: %0d cycles busy/done, required 0", dones);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        @(posedge clk); #1;
        x = 32'hDEAD_BEEF; y = 32'h0BAD_F00D; mul_signed = 1'b1; mul_start = 1'b1;
        @(posedge clk); #1;
        mul_start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        total += 5;
        if (busy      !== 1'b0) begin bad++; $display("FAIL reset_mid busy: %b required 0", busy); end
        if (pp_valid  !== 1'b0) begin bad++; $display("FAIL reset_mid pp_valid: %b required 0", pp_valid); end
        if (swt_begin !== 1'b0) begin bad++; $display("FAIL reset_mid swt_begin: %b required 0", swt_begin); end
        if (done      !== 1'b0) begin bad++; $display("FAIL reset_mid done: %b required 0", done); end
        if (pp_cols   !== '0)   begin bad++; $display("FAIL reset_mid pp_cols: nonzero, required 0"); end
        @(posedge clk); #2;
        resetn = 1'b1;
        start_op(32'h0000_1001, 32'h8000_0003, 1'b1, lat);
        check_latency("reset_mid", lat);
        compare_cols("reset_mid", 32'h0000_1001, 32'h8000_0003, 1'b1);
        finish_op("reset_mid");
    endtask

    task automatic test_back_to_back();
        int lat;
        @(posedge clk); #1;
        x = 32'hCAFE_0001; y = 32'h0000_0077; mul_signed = 1'b0; mul_start = 1'b1;
        @(posedge clk); #1;
        // mul_start stays high; new operands must wait until the next idle cycle.
        x = 32'h8000_0000; y = 32'h8000_0000; mul_signed = 1'b1;
        lat = 0;
        while (!swt_begin && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_latency("b2b_first", lat);
        compare_cols("b2b_first", 32'hCAFE_0001, 32'h0000_0077, 1'b0);
        finish_op("b2b_first");
        @(posedge clk); #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b restart: busy=%b required 1", busy);
        end
        mul_start = 1'b0;
        lat = 0;
        while (!swt_begin && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check_latency("b2b_second", lat);
        compare_cols("b2b_second", 32'h8000_0000, 32'h8000_0000, 1'b1);
        finish_op("b2b_second");
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        bit s;
        int lat;
        for (int k = 0; k < 16; k++) begin
            a = $urandom();
            b = $urandom();
            case (k % 4)
                1: b[31:30] = 2'b11;
                2: a = 32'h8000_0000;
                default: ;
            endcase
            s = $urandom_range(1, 0) == 1;
            start_op(a, b, s, lat);
            check_latency("random", lat);
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
            compare_cols("random", a, b, s);
            finish_op("random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
